// File: rtl/seq_restoring_divider.sv
// Sequential restoring (shift-subtract) divider: unsigned quotient and remainder,
// one quotient bit per SHIFT/TEST(/SUB) iteration, with Begin_div/End_div handshake.
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Begin_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             End_div,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    SHIFT = 3'd2,
    TEST  = 3'd3,
    SUB   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] div_r;
  logic [CW-1:0]    count_r;
  logic             ge_s;
  logic             last_s;

  assign ge_s    = (rem_r >= {1'b0, div_r});
  assign last_s  = (count_r == LAST_CNT);
  assign End_div = (state_r == IDLE);
  assign done    = (state_r == DONE);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = IDLE;
    case (state_r)
      IDLE:    if (Begin_div) state_s = INIT; else state_s = IDLE;
      INIT:    if (divisor == {WIDTH{1'b0}}) state_s = DONE; else state_s = SHIFT;
      SHIFT:   state_s = TEST;
      TEST: begin
        if (ge_s) state_s = SUB;
        else if (last_s) state_s = DONE;
        else state_s = SHIFT;
      end
      SUB:     if (last_s) state_s = DONE; else state_s = SHIFT;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath: operand capture, shift/subtract iterations and result load
  always_ff @(posedge clk) begin
    if (!reset) begin
      rem_r       <= {(WIDTH+1){1'b0}};
      quo_r       <= {WIDTH{1'b0}};
      div_r       <= {WIDTH{1'b0}};
      count_r     <= {CW{1'b0}};
      quotient    <= {WIDTH{1'b0}};
      remainder   <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        INIT: begin
          quo_r   <= dividend;
          div_r   <= divisor;
          rem_r   <= {(WIDTH+1){1'b0}};
          count_r <= {CW{1'b0}};
        end
        SHIFT: begin
          {rem_r, quo_r} <= {rem_r[WIDTH-1:0], quo_r, 1'b0};
        end
        TEST: begin
          // On a successful compare the counter advances in SUB instead
          if (!ge_s) begin
            if (last_s) count_r <= {CW{1'b0}};
            else        count_r <= count_r + CW'(1);
          end
        end
        SUB: begin
          rem_r    <= rem_r - {1'b0, div_r};
          quo_r[0] <= 1'b1;
          if (last_s) count_r <= {CW{1'b0}};
          else        count_r <= count_r + CW'(1);
        end
        DONE: begin
          // A zero divisor skipped the iterations, so quo_r still holds the dividend
          if (div_r == {WIDTH{1'b0}}) begin
            quotient    <= {WIDTH{1'b1}};
            remainder   <= quo_r;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= quo_r;
            remainder   <= rem_r[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
